uart_bus_responder: RTL
=======================

# uart_bus_responder

Memory-mapped UART peripheral that responds to the CPU's peripheral bus (rd/wr/addr/wdata/rdata) and drives the two interrupt lines. The CPU jumps to the ILLTX and ILLRX handlers on these lines. The block serialises bytes written by the CPU onto TX and deserialises RX into a readable register. It sits inside the peripheral subsystem next to the LED, switch and digit registers, and shares the bus decode with them.

## Interface
- CLKS_PER_BIT, 10417, clk cycles per UART bit (100 MHz / 9600 baud); minimum 8.
- BASE_ADDR, 32'h4000_0018, address of UART_TXD; UART_RXD = BASE+4, UART_CON = BASE+8.

- clk  in  1  system clock; the only clock.
- reset  in  1  asynchronous, active-low; block is in reset while 0.
- rd  in  1  bus read enable (level, may be held many clk cycles).
- wr  in  1  bus write enable (level, may be held many clk cycles).
- addr  in  32  bus address.
- wdata  in  32  write data.
- rdata  out  32  read data, combinational.
- RX  in  1  serial input, asynchronous to clk.
- TX  out  1  serial output, idle high.
- irqout  out  2  [0] TX-done interrupt, [1] RX-valid interrupt.

## Operation
- Frame format is 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
- Register map:
  - UART_TXD: write [7:0] starts a transmit. Read returns {24'b0, last byte written}.
  - UART_RXD: read returns {24'b0, rx_byte}.
  - UART_CON: bit0 tx_irq_en (R/W), bit1 rx_irq_en (R/W), bit2 tx_done (sticky, RO), bit3 rx_valid (RO), bit4 tx_busy (RO), bit5 rx_overrun (sticky, RO). All other bits read 0.
- Access qualification:
  - hit_X = (rd|wr) & addr==X.
  - Write actions fire once, on the first clk edge where wr & addr==X is 1 and was 0 on the previous edge (rising-edge detect).
  - Read side effects fire once, on the first edge where rd & addr==X is 0 after being 1, so data stays stable for the whole access.
- rdata = 0 when rd=0 or the address is unmapped. Unmapped writes are ignored.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a TXD write edge: latch byte, tx_busy=1, tx_done=0.
  - Each state lasts CLKS_PER_BIT cycles. DATA steps through bits 0..7.
  - STOP -> IDLE: tx_busy=0, tx_done=1.
  - A TXD write while tx_busy=1 updates nothing: the frame in flight and the readback byte are both unchanged.
- RX path: 2-flop synchroniser on RX, then FSM with states IDLE, START, DATA, STOP.
  - IDLE -> START on a synchronised 1->0 transition.
  - START: wait CLKS_PER_BIT/2 (integer division). If the line is 1, abort to IDLE; otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, shifting LSB first.
  - STOP: sample once. If 1, load rx_byte and set rx_valid; if rx_valid was already 1, also set rx_overrun (the new byte overwrites). If 0 (framing error), discard the byte and leave flags unchanged. Either way return to IDLE.
- Clearing: the read-end edge of UART_RXD clears rx_valid. The read-end edge of UART_CON clears tx_done and rx_overrun.
- Writes to UART_CON update only bits 1:0.
- irqout[0] = tx_done & tx_irq_en; irqout[1] = rx_valid & rx_irq_en.
- Simultaneous events: a set (completing frame) in the same cycle as a clear (read-end) resolves as set wins.

## Timing
- Reset values: TX=1, rdata=0, irqout=0, all CON bits 0, rx_byte=0, TXD readback 0, both FSMs IDLE, bit counters 0.
- Reset asserted mid-frame: TX goes to 1 immediately (asynchronous), and the partial RX byte is lost.
- TX start latency: TX falls on the clk edge that detects the write edge (1 cycle after wr is first sampled high). tx_busy rises on the same edge.
- TX frame length: exactly 10*CLKS_PER_BIT cycles from TX falling to tx_done=1. tx_done and irqout[0] rise on the same edge as tx_busy falls.
- RX latency: rx_valid rises 9*CLKS_PER_BIT + CLKS_PER_BIT/2 + 2..3 cycles after the RX pin falls. The +2..3 is synchroniser plus edge detect.
- Flag clear: rx_valid falls 1 cycle after rd (addressing UART_RXD) deasserts.
- Counter boundaries: the bit counter wraps 0..CLKS_PER_BIT-1. The data index ends at 7 with no wrap into the next frame; STOP always follows.

## Test plan
- Reset, then read all three registers: rdata=0, TX=1, irqout=2'b00.
- CLKS_PER_BIT=16, write 0x000000A5 to TXD with wr held 40 cycles:
  - TX bits are 0,1,0,1,0,0,1,0,1,1, each 16 cycles; exactly one frame is sent.
  - tx_done rises 160 cycles after TX falls. With tx_irq_en=1, irqout[0]=1 until a CON read ends.
- Drive an RX frame for 0x3C at 16 cycles/bit: rx_valid=1, RXD reads 0x0000003C, irqout[1]=1 if enabled. After the RXD read ends, rx_valid=0.
- Send two RX frames (0x11, 0x22) without reading: rx_overrun=1 and RXD=0x22. Then a CON read ends: overrun=0 while rx_valid stays 1.
- Stimulus edge cases:
  - A 5-cycle low glitch on RX produces no rx_valid (start abort).
  - A frame whose stop bit is 0 produces no rx_valid and no byte change.
  - A TXD write of 0x77 mid-frame leaves the frame and the readback byte unchanged.
- Assert reset during the 4th TX data bit: TX=1 immediately. After release, a new write of 0x55 produces a clean full frame.

Source files
------------

// File: rtl/uart_bus_responder.sv
// uart_bus_responder
//   Memory-mapped 8N1 UART on the CPU peripheral bus.
//   Registers: TXD (BASE_ADDR), RXD (BASE_ADDR+4), CON (BASE_ADDR+8).
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   rd, wr         bus read/write enables (level, may be held for many cycles)
//   addr, wdata    bus address and write data
//   rdata          combinational read data (0 when idle or unmapped)
//   RX             serial input, asynchronous to clk
//   TX             serial output, idle high
//   irqout         [0] TX-done interrupt, [1] RX-valid interrupt
module uart_bus_responder #(
    parameter int          CLKS_PER_BIT = 10417,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        RX,
    output logic        TX,
    output logic [1:0]  irqout
);
    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [31:0]      TXD_ADDR  = BASE_ADDR;
    localparam logic [31:0]      RXD_ADDR  = BASE_ADDR + 32'd4;
    localparam logic [31:0]      CON_ADDR  = BASE_ADDR + 32'd8;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    // Bus access qualification. Writes act on the first cycle of an access,
    // read side effects on the cycle after it ends so rdata stays stable.
    logic wr_txd, wr_con, rd_rxd, rd_con;
    logic wr_txd_q, wr_con_q, rd_rxd_q, rd_con_q;
    logic txd_wr_edge, con_wr_edge, rxd_rd_end, con_rd_end;

    assign wr_txd      = wr && (addr == TXD_ADDR);
    assign wr_con      = wr && (addr == CON_ADDR);
    assign rd_rxd      = rd && (addr == RXD_ADDR);
    assign rd_con      = rd && (addr == CON_ADDR);
    assign txd_wr_edge = wr_txd & ~wr_txd_q;
    assign con_wr_edge = wr_con & ~wr_con_q;
    assign rxd_rd_end  = rd_rxd_q & ~rd_rxd;
    assign con_rd_end  = rd_con_q & ~rd_con;

    logic unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    logic tx_irq_en_q, rx_irq_en_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_txd_q    <= 1'b0;
            wr_con_q    <= 1'b0;
            rd_rxd_q    <= 1'b0;
            rd_con_q    <= 1'b0;
            tx_irq_en_q <= 1'b0;
            rx_irq_en_q <= 1'b0;
        end else begin
            wr_txd_q <= wr_txd;
            wr_con_q <= wr_con;
            rd_rxd_q <= rd_rxd;
            rd_con_q <= rd_con;
            if (con_wr_edge) begin
                tx_irq_en_q <= wdata[0];
                rx_irq_en_q <= wdata[1];
            end
        end
    end

    // Transmitter
    state_e           tx_state_q;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [2:0]       tx_idx_q;
    logic [7:0]       tx_byte_q;
    logic             tx_busy_q, tx_done_q, tx_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q <= S_IDLE;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_byte_q  <= '0;
            tx_busy_q  <= 1'b0;
            tx_done_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            // Clear first; a frame completing in this cycle overrides it.
            if (con_rd_end) tx_done_q <= 1'b0;
            case (tx_state_q)
                S_IDLE: begin
                    if (txd_wr_edge) begin
                        tx_byte_q  <= wdata[7:0];
                        tx_busy_q  <= 1'b1;
                        tx_done_q  <= 1'b0;
                        tx_q       <= 1'b0;
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        tx_state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_q       <= tx_byte_q[0];
                        tx_state_q <= S_DATA;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_idx_q == 3'd7) begin
                            tx_q       <= 1'b1;
                            tx_state_q <= S_STOP;
                        end else begin
                            tx_idx_q <= tx_idx_q + 3'd1;
                            tx_q     <= tx_byte_q[tx_idx_q + 3'd1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q   <= '0;
                        tx_idx_q   <= '0;
                        tx_busy_q  <= 1'b0;
                        tx_done_q  <= 1'b1;
                        tx_state_q <= S_IDLE;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + CNT_ONE;
                    end
                end
                default: tx_state_q <= S_IDLE;
            endcase
        end
    end

    // Receiver: rx_s1/rx_s2 synchronise, rx_s3 holds the previous value
    // for start-edge detection. Idle line is high.
    logic             rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
    state_e           rx_state_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [2:0]       rx_idx_q;
    logic [7:0]       rx_shift_q, rx_byte_q;
    logic             rx_valid_q, rx_ovr_q;

    assign rx_fall = rx_s3_q & ~rx_s2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ovr_q   <= 1'b0;
        end else begin
            rx_s1_q <= RX;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
            // Clears first; a good stop bit in this cycle overrides them.
            if (rxd_rd_end) rx_valid_q <= 1'b0;
            if (con_rd_end) rx_ovr_q   <= 1'b0;
            case (rx_state_q)
                S_IDLE: begin
                    if (rx_fall) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= S_START;
                    end
                end
                S_START: begin
                    // Half a bit in: a high line means the edge was a glitch.
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_idx_q   <= '0;
                        rx_state_q <= rx_s2_q ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_idx_q == 3'd7) begin
                            rx_idx_q   <= '0;
                            rx_state_q <= S_STOP;
                        end else begin
                            rx_idx_q <= rx_idx_q + 3'd1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_state_q <= S_IDLE;
                        // A low stop bit is a framing error: drop the byte.
                        if (rx_s2_q) begin
                            rx_byte_q  <= rx_shift_q;
                            rx_valid_q <= 1'b1;
                            if (rx_valid_q) rx_ovr_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + CNT_ONE;
                    end
                end
                default: rx_state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (addr == TXD_ADDR) begin
                rdata = {24'b0, tx_byte_q};
            end else if (addr == RXD_ADDR) begin
                rdata = {24'b0, rx_byte_q};
            end else if (addr == CON_ADDR) begin
                rdata = {26'b0, rx_ovr_q, tx_busy_q, rx_valid_q, tx_done_q,
                         rx_irq_en_q, tx_irq_en_q};
            end
        end
    end

    assign TX     = tx_q;
    assign irqout = {rx_valid_q & rx_irq_en_q, tx_done_q & tx_irq_en_q};

endmodule
